stack_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared LIFO `stack` block. Requesters 0 and 1 submit push/pop operations through a valid/ready handshake. The arbiter serialises them onto the stack's `push`/`pop`/`data_in` controls, guards against overflow and underflow using `full`/`empty`, and returns a tagged one-cycle response. It sits between the stack and its client blocks; the clients never drive the stack directly.

---
 rtl/stack_arbiter.sv | 107 ++++++++++
 tb/tb_stack_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for the shared LIFO stack.
// Serialises push/pop requests, blocks overflow/underflow, returns a tagged response.
module stack_arbiter #(
  parameter int data_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_valid_i,
  input  logic [1:0]            req_op_i,
  input  logic [data_width-1:0] req_data0_i,
  input  logic [data_width-1:0] req_data1_i,
  output logic [1:0]            req_ready_o,
  output logic                  rsp_valid_o,
  output logic                  rsp_id_o,
  output logic                  rsp_err_o,
  output logic [data_width-1:0] rsp_data_o,
  output logic                  stk_push_o,
  output logic                  stk_pop_o,
  output logic [data_width-1:0] stk_data_in_o,
  input  logic [data_width-1:0] stk_data_out_i,
  input  logic                  stk_full_i,
  input  logic                  stk_empty_i,
  output logic                  busy_o,
  output logic [7:0]            err_cnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                state_q;
  logic                  owner_q;
  logic                  op_q;
  logic [data_width-1:0] data_q;
  logic                  last_grant_q;
  logic                  err_q;
  logic [7:0]            err_cnt_q;
  logic [7:0]            err_cnt_d;

  logic winner;
  logic in_issue;
  logic reject;

  // On a tie the requester that was not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req_valid_i)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_q;
      default: winner = 1'b0;
    endcase
  end

  assign in_issue  = (state_q == ISSUE);
  assign reject    = op_q ? stk_empty_i : stk_full_i;
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    req_ready_o = 2'b00;
    if (state_q == IDLE && !rst_i && (req_valid_i != 2'b00))
      req_ready_o = winner ? 2'b10 : 2'b01;
  end

  assign stk_push_o    = in_issue && !op_q && !stk_full_i;
  assign stk_pop_o     = in_issue &&  op_q && !stk_empty_i;
  assign stk_data_in_o = stk_push_o ? data_q : '0;

  // Stack read data is already registered by the stack; pass it through in RESP.
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_id_o    = rsp_valid_o & owner_q;
  assign rsp_err_o   = rsp_valid_o & err_q;
  assign rsp_data_o  = (rsp_valid_o && op_q && !err_q) ? stk_data_out_i : '0;

  assign busy_o    = (state_q != IDLE);
  assign err_cnt_o = err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      op_q         <= 1'b0;
      data_q       <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i != 2'b00) begin
            owner_q      <= winner;
            op_q         <= winner ? req_op_i[1] : req_op_i[0];
            data_q       <= winner ? req_data1_i : req_data0_i;
            last_grant_q <= winner;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          err_q <= reject;
          if (reject) err_cnt_q <= err_cnt_d;
          state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: behavioural 4-deep stack, directed requests,
// expected responses queued at issue and checked by an independent monitor.
module tb_stack_arbiter;
  localparam int W = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_data0 = '0;
  logic [W-1:0] req_data1 = '0;
  logic [1:0]   req_ready;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] rsp_data;
  logic         stk_push, stk_pop;
  logic [W-1:0] stk_data_in;
  logic [W-1:0] stk_data_out;
  logic         stk_full, stk_empty;
  logic         busy;
  logic [7:0]   err_cnt;

  stack_arbiter #(.data_width(W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_op_i(req_op),
    .req_data0_i(req_data0), .req_data1_i(req_data1),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_err_o(rsp_err), .rsp_data_o(rsp_data),
    .stk_push_o(stk_push), .stk_pop_o(stk_pop), .stk_data_in_o(stk_data_in),
    .stk_data_out_i(stk_data_out), .stk_full_i(stk_full), .stk_empty_i(stk_empty),
    .busy_o(busy), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural LIFO: registered read data that holds until the next pop.
  logic [W-1:0] mem [DEPTH];
  logic [2:0]   sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= 3'd0;
      stk_data_out <= '0;
    end else if (stk_push && sp < 3'(DEPTH)) begin
      mem[sp[1:0]] <= stk_data_in;
      sp <= sp + 3'd1;
    end else if (stk_pop && sp != 3'd0) begin
      stk_data_out <= mem[sp[1:0] - 2'd1];
      sp <= sp - 3'd1;
    end
  end
  assign stk_full  = (sp == 3'(DEPTH));
  assign stk_empty = (sp == 3'd0);

  typedef struct packed {logic id; logic err; logic [W-1:0] data;} rsp_t;
  rsp_t exp_q[$];
  rsp_t exp_r;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = -100;
  int illegal = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshake timing, stack protocol, response scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if ((req_valid & req_ready) != 2'b00) hs_cyc = cyc;
      if ((stk_push && stk_pop) || (stk_push && stk_full) || (stk_pop && stk_empty) ||
          (!stk_push && stk_data_in != '0))
        illegal++;
      if (rsp_valid) begin
        check("rsp_latency", cyc - hs_cyc, 2);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rsp_unexpected: got id=%0d err=%0d data=0x%0h, none expected",
                   rsp_id, rsp_err, rsp_data);
        end else begin
          exp_r = exp_q.pop_front();
          check("rsp{id,err,data}", {rsp_id, rsp_err, rsp_data}, exp_r);
        end
      end
    end
  end

  task automatic do_op(input int id, input logic op, input logic [W-1:0] d,
                       input logic e_err, input logic [W-1:0] e_data);
    bit got = 0;
    exp_q.push_back(rsp_t'({id[0], e_err, e_data}));
    @(posedge clk); #1;
    req_op[id] = op;
    if (id == 0) req_data0 = d; else req_data1 = d;
    req_valid[id] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1; break; end
    end
    if (!got) check("ready_timeout", 0, 1);
    else check("ready_onehot", req_ready, (id == 0) ? 1 : 2);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check("drain", exp_q.size(), 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {req_ready, rsp_valid, rsp_id, rsp_err, rsp_data, stk_push, stk_pop,
            stk_data_in, busy, err_cnt};
  endfunction

  task automatic apply_reset();
    req_valid = 2'b00;
    rst = 1'b1;
    #1 check("reset_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // Sequential pushes by requester 0, pops by requester 1.
    apply_reset();
    do_op(0, 1'b0, 8'h11, 1'b0, 8'h00);
    do_op(0, 1'b0, 8'h22, 1'b0, 8'h00);
    do_op(1, 1'b1, 8'h00, 1'b0, 8'h22);
    do_op(1, 1'b1, 8'h00, 1'b0, 8'h11);
    drain();
    check("err_cnt_seq", err_cnt, 0);

    // Tie: both hold valid pushes from reset; grants must alternate 0,1,0,1.
    apply_reset();
    @(posedge clk); #1;
    req_op = 2'b00;
    req_data0 = 8'hA0;
    req_data1 = 8'hB0;
    for (int g = 0; g < 4; g++) exp_q.push_back(rsp_t'({g[0], 1'b0, 8'h00}));
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      got = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin got = 1; break; end
      end
      check("tie_grant", req_ready, (g % 2 == 0) ? 1 : 2);
      @(posedge clk); #1;
      if (g == 3) req_valid = 2'b00;
    end
    do_op(0, 1'b1, 8'h00, 1'b0, 8'hB0);
    do_op(0, 1'b1, 8'h00, 1'b0, 8'hA0);
    do_op(0, 1'b1, 8'h00, 1'b0, 8'hB0);
    do_op(0, 1'b1, 8'h00, 1'b0, 8'hA0);
    drain();

    // Underflow right after reset.
    apply_reset();
    do_op(0, 1'b1, 8'h00, 1'b1, 8'h00);
    drain();
    check("err_cnt_underflow", err_cnt, 1);

    // Overflow: fill, reject one push, then pop.
    for (int i = 0; i < DEPTH; i++) do_op(1, 1'b0, 8'hFF, 1'b0, 8'h00);
    drain();
    check("stk_full_after_fill", stk_full, 1);
    do_op(1, 1'b0, 8'h11, 1'b1, 8'h00);
    drain();
    check("err_cnt_overflow", err_cnt, 2);
    do_op(0, 1'b1, 8'h00, 1'b0, 8'hFF);
    drain();
    check("err_cnt_after_pop", err_cnt, 2);

    // Reset asserted during ISSUE of a push of 0x55.
    @(posedge clk); #1;
    req_op[0] = 1'b0;
    req_data0 = 8'h55;
    req_valid[0] = 1'b1;
    @(negedge clk);
    check("midrst_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #1 check("midrst_issue_push", {stk_push, stk_data_in}, {1'b1, 8'h55});
    rst = 1'b1;
    #1 check("midrst_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_stack_empty", stk_empty, 1);
    do_op(0, 1'b1, 8'h00, 1'b1, 8'h00);
    drain();
    check("err_cnt_midrst", err_cnt, 1);

    // Saturation: 300 pops on an empty stack.
    for (int i = 0; i < 100; i++) do_op(i % 2, 1'b1, 8'h00, 1'b1, 8'h00);
    drain();
    check("err_cnt_101", err_cnt, 101);
    for (int i = 0; i < 200; i++) do_op(i % 2, 1'b1, 8'h00, 1'b1, 8'h00);
    drain();
    check("err_cnt_sat", err_cnt, 255);
    repeat (3) @(posedge clk);
    #1 check("err_cnt_hold", err_cnt, 255);

    check("stack_protocol", illegal, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
